// File: rtl/mem_port_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_master_if
//  Purpose  : Core request/response channel plus DataMEM bus for one port.
//             The master modport is the port-initiator view; the slave
//             modport is the view of the core and memory around it.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_port_master_if #(
    parameter int TAM = 16
) ();
    // core request channel
    logic           req_valid;
    logic           req_ready;
    logic           req_we;
    logic [TAM-1:0] req_addr;
    logic [TAM-1:0] req_wdata;
    // core response channel
    logic           rsp_valid;
    logic           rsp_ready;
    logic [TAM-1:0] rsp_data;
    // status
    logic           err;
    logic           busy;
    // DataMEM bus
    logic [TAM-1:0] dataADDR;
    logic [TAM-1:0] dataIN;
    logic           dataWrite;
    logic           dataLoad;
    logic [TAM-1:0] dataOUT;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, dataOUT,
        output req_ready, rsp_valid, rsp_data, err, busy,
               dataADDR, dataIN, dataWrite, dataLoad
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, dataOUT,
        input  req_ready, rsp_valid, rsp_data, err, busy,
               dataADDR, dataIN, dataWrite, dataLoad
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_master.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_master
//  Purpose  : Core-side initiator for one DataMEM port. Buffers load/store
//             requests in an in-order queue, issues one memory access at a
//             time and returns load data on a valid/ready response channel.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_master #(
    parameter int TAM   = 16,
    parameter int Lmem  = 8,
    parameter int DEPTH = 4,
    parameter int RDLAT = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_port_master_if.master  bus
);

    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam int c_wait_w = $clog2(RDLAT + 1);
    localparam int c_ent_w  = 1 + Lmem + TAM;

    localparam logic [c_cnt_w-1:0]  c_depth = c_cnt_w'(DEPTH);
    localparam logic [c_wait_w-1:0] c_rdlat = c_wait_w'(RDLAT);
    localparam logic [c_wait_w-1:0] c_one   = c_wait_w'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t                r_state;
    logic [c_ent_w-1:0]    r_mem [DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;
    logic [c_wait_w-1:0]   r_wait;

    logic                  r_rsp_valid;
    logic [TAM-1:0]        r_rsp_data;
    logic                  r_err;
    logic [TAM-1:0]        r_data_addr;
    logic [TAM-1:0]        r_data_in;
    logic                  r_data_write;
    logic                  r_data_load;

    logic                  w_req_ready;
    logic                  w_addr_ok;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_avail;
    logic [c_ent_w-1:0]    w_in_entry;
    logic [c_ent_w-1:0]    w_head;
    logic                  w_head_we;
    logic [Lmem-1:0]       w_head_addr;
    logic [TAM-1:0]        w_head_wdata;

    assign w_req_ready = (r_count < c_depth);
    assign w_addr_ok   = ((bus.req_addr >> Lmem) == '0);
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_push      = w_accept && w_addr_ok;
    assign w_in_entry  = {bus.req_we, bus.req_addr[Lmem-1:0], bus.req_wdata};

    // An empty queue forwards the incoming request straight to the FSM so an
    // access can issue on the cycle right after acceptance.
    assign w_head       = (r_count == '0) ? w_in_entry : r_mem[r_rd_ptr];
    assign w_avail      = (r_count != '0) || w_push;
    assign w_pop        = w_avail && ((r_state == ST_IDLE) || (r_state == ST_WRITE));
    assign w_head_we    = w_head[c_ent_w-1];
    assign w_head_addr  = w_head[TAM +: Lmem];
    assign w_head_wdata = w_head[TAM-1:0];

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.err       = r_err;
    assign bus.busy      = (r_count != '0) || (r_state != ST_IDLE);
    assign bus.dataADDR  = r_data_addr;
    assign bus.dataIN    = r_data_in;
    assign bus.dataWrite = r_data_write;
    assign bus.dataLoad  = r_data_load;

    // Queue storage; stale entries are harmless because pointers and count
    // are what define occupancy.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    // Queue pointers, occupancy count and the out-of-range error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_accept && !w_addr_ok;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Access sequencer: issues one memory access at a time, strobes are
    // registered so each lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wait       <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_data_addr  <= '0;
            r_data_in    <= '0;
            r_data_write <= 1'b0;
            r_data_load  <= 1'b0;
        end else begin
            r_data_write <= 1'b0;
            r_data_load  <= 1'b0;
            case (r_state)
                ST_IDLE, ST_WRITE: begin
                    if (w_avail) begin
                        r_data_addr <= TAM'(w_head_addr);
                        if (w_head_we) begin
                            r_data_in    <= w_head_wdata;
                            r_data_write <= 1'b1;
                            r_state      <= ST_WRITE;
                        end else begin
                            r_data_load  <= 1'b1;
                            r_state      <= ST_READ;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    r_wait  <= c_rdlat;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // dataOUT is valid on the cycle the counter sits at one
                    if (r_wait == c_one) begin
                        r_rsp_data  <= bus.dataOUT;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_master
//  Purpose  : Directed and scoreboarded bench for mem_port_master with a
//             one-cycle-latency DataMEM model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    logic [15:0] mem_model [256];
    logic [15:0] sb [256];

    mem_port_master_if #(.TAM(16)) bus ();

    mem_port_master #(
        .TAM   (16),
        .Lmem  (8),
        .DEPTH (4),
        .RDLAT (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // DataMEM model: writes land at the edge, reads appear one cycle later
    always @(posedge clk) begin
        if (bus.dataWrite) mem_model[bus.dataADDR[7:0]] <= bus.dataIN;
        if (bus.dataLoad)  bus.dataOUT <= mem_model[bus.dataADDR[7:0]];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h0;
        bus.req_wdata = 16'h0;
    endtask

    task automatic drive_req(input logic we, input logic [15:0] a, input logic [15:0] d);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_drain: busy=%b required 0 after %0d cycles", tag, bus.busy, n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [53:0] obs;
        logic [53:0] exp;
        exp = {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0};
        rst = 1'b1;
        idle_inputs();
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        obs = {bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.err, bus.busy,
               bus.dataADDR, bus.dataIN, bus.dataWrite, bus.dataLoad};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL reset_during: got %h required %h", obs, exp);
        end
        rst = 1'b0;
        @(negedge clk);
        obs = {bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.err, bus.busy,
               bus.dataADDR, bus.dataIN, bus.dataWrite, bus.dataLoad};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL reset_after: got %h required %h", obs, exp);
        end
    endtask

    task automatic test_store_load();
        @(negedge clk);
        drive_req(1'b1, 16'h0010, 16'hBEEF);
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL sl_ready: got %b required 1", bus.req_ready);
        end
        @(negedge clk);
        vectors++;
        if ({bus.dataWrite, bus.dataLoad, bus.dataADDR, bus.dataIN} !== {1'b1, 1'b0, 16'h0010, 16'hBEEF}) begin
            miscompares++;
            $display("FAIL sl_write: got we=%b ld=%b a=%h d=%h required 1 0 0010 beef",
                     bus.dataWrite, bus.dataLoad, bus.dataADDR, bus.dataIN);
        end
        drive_req(1'b0, 16'h0010, 16'h0);
        @(negedge clk);
        idle_inputs();
        vectors++;
        if ({bus.dataWrite, bus.dataLoad, bus.dataADDR} !== {1'b0, 1'b1, 16'h0010}) begin
            miscompares++;
            $display("FAIL sl_load: got we=%b ld=%b a=%h required 0 1 0010",
                     bus.dataWrite, bus.dataLoad, bus.dataADDR);
        end
        @(negedge clk);
        vectors++;
        if (bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL sl_early_rsp: got %b required 0", bus.rsp_valid);
        end
        @(negedge clk);
        vectors++;
        if ({bus.rsp_valid, bus.rsp_data, bus.err} !== {1'b1, 16'hBEEF, 1'b0}) begin
            miscompares++;
            $display("FAIL sl_rsp: got v=%b d=%h err=%b required 1 beef 0",
                     bus.rsp_valid, bus.rsp_data, bus.err);
        end
        @(negedge clk);
        vectors++;
        if (bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL sl_rsp_drop: got %b required 0", bus.rsp_valid);
        end
        drain("sl");
    endtask

    task automatic test_back_to_back();
        int j = 0;
        int got = 0;
        for (int k = 0; k < 5; k++) begin
            if (k >= 1) begin
                vectors++;
                if ({bus.dataWrite, bus.dataLoad, bus.dataADDR, bus.dataIN} !==
                    {1'b1, 1'b0, 16'(k - 1), 16'(k)}) begin
                    miscompares++;
                    $display("FAIL b2b_write%0d: got we=%b ld=%b a=%h d=%h required 1 0 %h %h",
                             k - 1, bus.dataWrite, bus.dataLoad, bus.dataADDR, bus.dataIN,
                             16'(k - 1), 16'(k));
                end
            end
            if (k < 4) drive_req(1'b1, 16'(k), 16'(k + 1));
            else       idle_inputs();
            @(negedge clk);
        end
        for (int c = 0; c < 60 && got < 4; c++) begin
            if (bus.rsp_valid) begin
                vectors++;
                if (bus.rsp_data !== 16'(got + 1)) begin
                    miscompares++;
                    $display("FAIL b2b_rsp%0d: got %h required %h", got, bus.rsp_data, 16'(got + 1));
                end
                got++;
            end
            if (j < 4) begin
                drive_req(1'b0, 16'(j), 16'h0);
                j++;
            end else begin
                idle_inputs();
            end
            @(negedge clk);
        end
        idle_inputs();
        vectors++;
        if (got != 4) begin
            miscompares++;
            $display("FAIL b2b_rsp_count: got %0d required 4", got);
        end
        drain("b2b");
    endtask

    task automatic test_backpressure();
        int n = 0;
        int idx = 0;
        int acc = 0;
        int rsp_cnt = 0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        drive_req(1'b0, 16'h0002, 16'h0);
        @(negedge clk);
        idle_inputs();
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, 16'h0003}) begin
            miscompares++;
            $display("FAIL bp_first_rsp: got v=%b d=%h required 1 0003", bus.rsp_valid, bus.rsp_data);
        end
        for (int c = 0; c < 10; c++) begin
            drive_req(1'b1, 16'h0020 + 16'(idx), 16'h00A0 + 16'(idx));
            if (bus.req_ready && idx < 5) begin
                acc++;
                idx++;
            end
            @(negedge clk);
        end
        vectors++;
        if (acc != 4) begin
            miscompares++;
            $display("FAIL bp_accepted: got %0d required 4", acc);
        end
        vectors++;
        if (bus.req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_full_ready: got %b required 0", bus.req_ready);
        end
        vectors++;
        if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, 16'h0003}) begin
            miscompares++;
            $display("FAIL bp_rsp_hold: got v=%b d=%h required 1 0003", bus.rsp_valid, bus.rsp_data);
        end
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 40 && idx < 5; c++) begin
            if (bus.rsp_valid) rsp_cnt++;
            if (bus.req_ready) begin
                idx++;
                acc++;
            end
            @(negedge clk);
        end
        idle_inputs();
        for (int c = 0; c < 40 && bus.busy; c++) begin
            if (bus.rsp_valid) rsp_cnt++;
            @(negedge clk);
        end
        vectors++;
        if (acc != 5 || rsp_cnt != 1) begin
            miscompares++;
            $display("FAIL bp_drain: got acc=%0d rsps=%0d required 5 1", acc, rsp_cnt);
        end
        vectors++;
        if ({bus.req_ready, bus.busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL bp_ready_back: got ready=%b busy=%b required 1 0", bus.req_ready, bus.busy);
        end
        drive_req(1'b0, 16'h0024, 16'h0);
        @(negedge clk);
        idle_inputs();
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, 16'h00A4}) begin
            miscompares++;
            $display("FAIL bp_last_store: got v=%b d=%h required 1 00a4", bus.rsp_valid, bus.rsp_data);
        end
        drain("bp");
    endtask

    task automatic test_bad_addr();
        bit saw = 0;
        @(negedge clk);
        drive_req(1'b0, 16'h0100, 16'h0);
        @(negedge clk);
        idle_inputs();
        vectors++;
        if ({bus.err, bus.dataLoad, bus.busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL bad_err: got err=%b ld=%b busy=%b required 1 0 0",
                     bus.err, bus.dataLoad, bus.busy);
        end
        @(negedge clk);
        vectors++;
        if ({bus.err, bus.dataLoad, bus.busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL bad_err_pulse: got err=%b ld=%b busy=%b required 0 0 0",
                     bus.err, bus.dataLoad, bus.busy);
        end
        for (int c = 0; c < 6; c++) begin
            if (bus.rsp_valid || bus.dataLoad || bus.busy) saw = 1;
            @(negedge clk);
        end
        vectors++;
        if (saw) begin
            miscompares++;
            $display("FAIL bad_no_access: got activity=1 required 0");
        end
    endtask

    task automatic test_reset_midop();
        bit saw = 0;
        logic [53:0] obs;
        @(negedge clk);
        drive_req(1'b0, 16'h0010, 16'h0);
        @(negedge clk);
        idle_inputs();
        vectors++;
        if (bus.dataLoad !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_load: got %b required 1", bus.dataLoad);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        obs = {bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.err, bus.busy,
               bus.dataADDR, bus.dataIN, bus.dataWrite, bus.dataLoad};
        vectors++;
        if (obs !== {1'b1, 53'h0}) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: got %h required %h", obs, {1'b1, 53'h0});
        end
        for (int c = 0; c < 8; c++) begin
            if (bus.rsp_valid || bus.busy) saw = 1;
            @(negedge clk);
        end
        vectors++;
        if (saw) begin
            miscompares++;
            $display("FAIL rst_mid_no_rsp: got activity=1 required 0");
        end
    endtask

    task automatic test_random();
        int issued = 0;
        int coll = 0;
        bit have = 0;
        logic we;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] e;
        logic [7:0] wr_addrs[$];
        logic [15:0] exp_q[$];
        for (int c = 0; c < 20000 && (issued < 1000 || exp_q.size() != 0 || bus.busy); c++) begin
            @(negedge clk);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            if (bus.rsp_valid && bus.rsp_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rnd_extra_rsp: got unexpected rsp %h required none", bus.rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.rsp_data !== e) begin
                        miscompares++;
                        $display("FAIL rnd_rsp: got %h required %h", bus.rsp_data, e);
                    end
                end
            end
            if (bus.dataWrite && bus.dataLoad) coll++;
            if (!have && issued < 1000) begin
                if (issued % 2 == 0) begin
                    we = 1'b1;
                    a  = 16'($urandom_range(0, 255));
                    d  = 16'($urandom);
                end else begin
                    we = 1'b0;
                    a  = {8'h0, wr_addrs[$urandom_range(0, wr_addrs.size() - 1)]};
                    d  = 16'h0;
                end
                have = 1;
            end
            if (have) drive_req(we, a, d);
            else      idle_inputs();
            if (have && bus.req_ready) begin
                if (we) begin
                    sb[a[7:0]] = d;
                    wr_addrs.push_back(a[7:0]);
                end else begin
                    exp_q.push_back(sb[a[7:0]]);
                end
                issued++;
                have = 0;
            end
        end
        idle_inputs();
        bus.rsp_ready = 1'b1;
        vectors++;
        if (issued != 1000 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rnd_complete: got issued=%0d pending=%0d required 1000 0", issued, exp_q.size());
        end
        vectors++;
        if (coll != 0) begin
            miscompares++;
            $display("FAIL rnd_strobe_overlap: got %0d cycles required 0", coll);
        end
    endtask

    initial begin
        bus.rsp_ready = 1'b1;
        idle_inputs();
        test_reset();
        test_store_load();
        test_back_to_back();
        test_backpressure();
        test_bad_addr();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
